// File: rtl/return_coin_sequencer.sv
// Balance-return controller for the vending machine.
// Runs the inactivity timer, latches the balance on timeout or a user request,
// and hands coins one at a time, largest value first, to the hopper over valid/ready.
module return_coin_sequencer #(
  parameter int unsigned TOTAL_BITS  = 31,
  parameter int unsigned COIN0_VALUE = 100,
  parameter int unsigned COIN1_VALUE = 500,
  parameter int unsigned COIN2_VALUE = 1000,
  parameter int unsigned WAIT_TIME   = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_activity,
  input  logic                  i_trigger_return,
  input  logic [TOTAL_BITS-1:0] i_current_total,
  input  logic                  i_hopper_ready,
  output logic [31:0]           o_wait_time,
  output logic [2:0]            o_return_coin,
  output logic                  o_return_valid,
  output logic [TOTAL_BITS-1:0] o_return_total,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_residual
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_LATCH,
    S_RETURN,
    S_DONE
  } state_t;

  localparam logic [TOTAL_BITS-1:0] C0      = TOTAL_BITS'(COIN0_VALUE);
  localparam logic [TOTAL_BITS-1:0] C1      = TOTAL_BITS'(COIN1_VALUE);
  localparam logic [TOTAL_BITS-1:0] C2      = TOTAL_BITS'(COIN2_VALUE);
  localparam logic [31:0]           WT_INIT = 32'(WAIT_TIME);

  state_t                  state_q, state_d;
  logic [31:0]             wait_q, wait_d;
  logic [TOTAL_BITS-1:0]   rem_q, rem_d;
  logic [2:0]              coin_q, coin_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    residual_q, residual_d;
  logic                    accept;

  // Largest coin that still fits into the remaining amount; zero when none fits.
  function automatic logic [2:0] pick_coin(input logic [TOTAL_BITS-1:0] r);
    if (r >= C2)      return 3'b100;
    else if (r >= C1) return 3'b010;
    else if (r >= C0) return 3'b001;
    else              return 3'b000;
  endfunction

  function automatic logic [TOTAL_BITS-1:0] coin_value(input logic [2:0] c);
    case (c)
      3'b100:  return C2;
      3'b010:  return C1;
      3'b001:  return C0;
      default: return '0;
    endcase
  endfunction

  assign accept         = valid_q & i_hopper_ready;
  assign o_return_total = accept ? coin_value(coin_q) : '0;

  assign o_wait_time    = wait_q;
  assign o_return_coin  = coin_q;
  assign o_return_valid = valid_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_residual     = residual_q;

  // State and output registers; reset drops any in-flight coin.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      wait_q     <= '0;
      rem_q      <= '0;
      coin_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      residual_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      rem_q      <= rem_d;
      coin_q     <= coin_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      residual_q <= residual_d;
    end
  end

  // Next-state selection; a registered valid of 0 in RETURN means nothing is left to pay out.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_trigger_return)  state_d = S_LATCH;
        else if (i_activity)   state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_trigger_return)                       state_d = S_LATCH;
        else if (!i_activity && wait_q == 32'd1)    state_d = S_LATCH;
      end
      S_LATCH:  state_d = S_RETURN;
      S_RETURN: if (!valid_q) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath.
  // The coin is chosen from the next remaining amount so it is already valid on the
  // first RETURN cycle and right after each accept.
  always_comb begin
    wait_d     = wait_q;
    rem_d      = rem_q;
    coin_d     = coin_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    residual_d = residual_q;
    busy_d     = (state_d == S_LATCH) || (state_d == S_RETURN) || (state_d == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (state_d == S_WAIT) wait_d = WT_INIT;
      end
      S_WAIT: begin
        if (i_activity)          wait_d = WT_INIT;
        else if (wait_q != '0)   wait_d = wait_q - 32'd1;
      end
      S_LATCH: begin
        rem_d   = i_current_total;
        coin_d  = pick_coin(i_current_total);
        valid_d = (coin_d != 3'b000);
      end
      S_RETURN: begin
        if (!valid_q) begin
          coin_d     = '0;
          valid_d    = 1'b0;
          done_d     = 1'b1;
          residual_d = (rem_q != '0);
        end else if (i_hopper_ready) begin
          rem_d   = rem_q - coin_value(coin_q);
          coin_d  = pick_coin(rem_d);
          valid_d = (coin_d != 3'b000);
        end
      end
      default: begin
      end
    endcase
    if (state_d == S_LATCH) begin
      wait_d     = '0;
      residual_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_return_coin_sequencer.sv
// Self-checking bench for return_coin_sequencer: table-driven return scenarios with
// a coin scoreboard, plus hand-written reload, priority and reset sequences.
module tb_return_coin_sequencer;

  localparam int unsigned TB_BITS = 31;
  localparam int          BUDGET  = 80;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               i_activity;
  logic               i_trigger_return;
  logic [TB_BITS-1:0] i_current_total;
  logic               i_hopper_ready;
  logic [31:0]        o_wait_time;
  logic [2:0]         o_return_coin;
  logic               o_return_valid;
  logic [TB_BITS-1:0] o_return_total;
  logic               o_busy;
  logic               o_done;
  logic               o_residual;

  return_coin_sequencer #(
    .TOTAL_BITS (TB_BITS),
    .COIN0_VALUE(100),
    .COIN1_VALUE(500),
    .COIN2_VALUE(1000),
    .WAIT_TIME  (10)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_activity      (i_activity),
    .i_trigger_return(i_trigger_return),
    .i_current_total (i_current_total),
    .i_hopper_ready  (i_hopper_ready),
    .o_wait_time     (o_wait_time),
    .o_return_coin   (o_return_coin),
    .o_return_valid  (o_return_valid),
    .o_return_total  (o_return_total),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_residual      (o_residual)
  );

  always #5 clk = ~clk;

  typedef enum int {M_TIMEOUT, M_TRIG_IDLE, M_TRIG_WAIT} mode_e;

  typedef struct {
    int unsigned total;
    mode_e       mode;
    int unsigned stall;
    int unsigned exp_n;
    bit          exp_res;
  } vec_t;

  vec_t       vecs[8];
  logic [2:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         n_accepts = 0;
  bit         prev_hold = 1'b0;
  logic [2:0] prev_coin = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned coin_val(input logic [2:0] c);
    if (c == 3'b100) return 1000;
    if (c == 3'b010) return 500;
    if (c == 3'b001) return 100;
    return 0;
  endfunction

  // Greedy breakdown computed by division, independently of the DUT's compare chain.
  task automatic push_coins(input int unsigned total);
    int unsigned r;
    r = total;
    for (int unsigned k = 0; k < total / 1000; k++) exp_q.push_back(3'b100);
    r = r % 1000;
    for (int unsigned k = 0; k < r / 500; k++) exp_q.push_back(3'b010);
    r = r % 500;
    for (int unsigned k = 0; k < r / 100; k++) exp_q.push_back(3'b001);
  endtask

  // Scoreboard monitor: compares every accepted coin and checks hold stability.
  always @(negedge clk) begin
    logic [2:0] e;
    if (o_return_valid && i_hopper_ready) begin
      n_accepts++;
      if (exp_q.size() == 0) begin
        chk("unexpected_accept", o_return_coin, 0);
      end else begin
        e = exp_q.pop_front();
        chk("coin", o_return_coin, e);
        chk("return_total", o_return_total, coin_val(e));
      end
    end else begin
      chk("return_total_idle", o_return_total, 0);
    end
    if (prev_hold && reset_n) begin
      chk("hold_valid", o_return_valid, 1);
      chk("hold_coin", o_return_coin, prev_coin);
    end
    prev_hold = o_return_valid && !i_hopper_ready && reset_n;
    prev_coin = o_return_coin;
  end

  // Runs from the LATCH cycle (index 1) until DONE, applying first-coin backpressure.
  task automatic finish_return(input int unsigned exp_n, input bit exp_res,
                               input int unsigned stall, input bit check_idx);
    int unsigned valid_cyc;
    int unsigned stalled;
    bit          done_seen;
    valid_cyc = 0;
    stalled   = 0;
    done_seen = 1'b0;
    for (int cyc = 2; cyc <= BUDGET && !done_seen; cyc++) begin
      tick();
      if (cyc == 2 && exp_n > 0) chk("first_valid_latency", o_return_valid, 1);
      if (o_return_valid) begin
        valid_cyc++;
        if (stalled < stall) begin
          i_hopper_ready = 1'b0;
          stalled++;
        end else begin
          i_hopper_ready = 1'b1;
        end
      end else begin
        i_hopper_ready = 1'b1;
      end
      if (o_done) begin
        done_seen = 1'b1;
        chk("residual", o_residual, exp_res);
        chk("done_valid_low", o_return_valid, 0);
        if (check_idx) chk("done_cycle", cyc, 3);
      end
    end
    if (!done_seen) chk("done_timeout", 0, 1);
    tick();
    chk("done_one_cycle", o_done, 0);
    chk("idle_after_done", o_busy, 0);
    chk("accept_count", n_accepts, exp_n);
    chk("valid_cycles", valid_cyc, (exp_n == 0) ? 0 : exp_n + stall);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  task automatic run_vec(input vec_t v);
    n_accepts       = 0;
    i_current_total = TB_BITS'(v.total);
    i_hopper_ready  = 1'b1;
    push_coins(v.total);
    case (v.mode)
      M_TIMEOUT: begin
        i_activity = 1'b1;
        tick();
        i_activity = 1'b0;
        chk("wait_load", o_wait_time, 10);
        for (int k = 9; k >= 0; k--) begin
          tick();
          chk("wait_count", o_wait_time, k);
          chk("busy_during_wait", o_busy, (k == 0) ? 1 : 0);
        end
        chk("latch_valid_low", o_return_valid, 0);
      end
      M_TRIG_WAIT: begin
        i_activity = 1'b1;
        tick();
        i_activity = 1'b0;
        for (int k = 0; k < 20 && o_wait_time != 7; k++) tick();
        chk("wait_reach_7", o_wait_time, 7);
        i_trigger_return = 1'b1;
        tick();
        i_trigger_return = 1'b0;
        chk("latch_busy", o_busy, 1);
        chk("latch_wait_zero", o_wait_time, 0);
      end
      default: begin
        i_trigger_return = 1'b1;
        tick();
        i_trigger_return = 1'b0;
        chk("latch_busy", o_busy, 1);
        chk("latch_valid_low", o_return_valid, 0);
      end
    endcase
    finish_return(v.exp_n, v.exp_res, v.stall, v.exp_n == 0);
  endtask

  initial begin
    vecs[0] = '{total: 1600, mode: M_TIMEOUT,   stall: 0, exp_n: 3, exp_res: 1'b0};
    vecs[1] = '{total: 500,  mode: M_TRIG_IDLE, stall: 3, exp_n: 1, exp_res: 1'b0};
    vecs[2] = '{total: 1650, mode: M_TRIG_WAIT, stall: 0, exp_n: 3, exp_res: 1'b1};
    vecs[3] = '{total: 0,    mode: M_TRIG_IDLE, stall: 0, exp_n: 0, exp_res: 1'b0};
    vecs[4] = '{total: 3750, mode: M_TRIG_IDLE, stall: 2, exp_n: 6, exp_res: 1'b1};
    vecs[5] = '{total: 99,   mode: M_TRIG_IDLE, stall: 0, exp_n: 0, exp_res: 1'b1};
    vecs[6] = '{total: 100,  mode: M_TIMEOUT,   stall: 1, exp_n: 1, exp_res: 1'b0};
    vecs[7] = '{total: 2999, mode: M_TRIG_IDLE, stall: 0, exp_n: 7, exp_res: 1'b1};

    reset_n          = 1'b0;
    i_activity       = 1'b0;
    i_trigger_return = 1'b0;
    i_current_total  = '0;
    i_hopper_ready   = 1'b0;
    tick();
    tick();
    chk("rst_wait", o_wait_time, 0);
    chk("rst_valid", o_return_valid, 0);
    chk("rst_coin", o_return_coin, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_residual", o_residual, 0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset while idle clears the sticky residual left by the last vector.
    chk("residual_before_reset", o_residual, 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("residual_after_reset", o_residual, 0);
    tick();

    // Activity reload at wait_time 3, then a full 10-cycle timeout with zero balance.
    n_accepts       = 0;
    i_current_total = '0;
    i_activity      = 1'b1;
    tick();
    i_activity = 1'b0;
    for (int k = 0; k < 20 && o_wait_time != 3; k++) tick();
    chk("reload_reach_3", o_wait_time, 3);
    i_activity = 1'b1;
    tick();
    i_activity = 1'b0;
    chk("reload_value", o_wait_time, 10);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("reload_count", o_wait_time, 10 - k);
      chk("reload_busy", o_busy, (k == 10) ? 1 : 0);
    end
    finish_return(0, 1'b0, 0, 1'b1);

    // Trigger and activity together in IDLE: trigger wins.
    n_accepts        = 0;
    i_activity       = 1'b1;
    i_trigger_return = 1'b1;
    tick();
    i_activity       = 1'b0;
    i_trigger_return = 1'b0;
    chk("both_busy", o_busy, 1);
    chk("both_wait", o_wait_time, 0);
    finish_return(0, 1'b0, 0, 1'b1);

    // Reset while a coin is held by backpressure: coin dropped, no accept.
    n_accepts        = 0;
    i_current_total  = TB_BITS'(500);
    i_hopper_ready   = 1'b0;
    i_trigger_return = 1'b1;
    tick();
    i_trigger_return = 1'b0;
    tick();
    chk("mid_valid", o_return_valid, 1);
    chk("mid_coin", o_return_coin, 3'b010);
    reset_n = 1'b0;
    tick();
    chk("mid_rst_valid", o_return_valid, 0);
    chk("mid_rst_coin", o_return_coin, 0);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_done", o_done, 0);
    chk("mid_rst_residual", o_residual, 0);
    chk("mid_rst_wait", o_wait_time, 0);
    chk("mid_rst_total", o_return_total, 0);
    reset_n        = 1'b1;
    i_hopper_ready = 1'b1;
    repeat (3) tick();
    chk("post_rst_valid", o_return_valid, 0);
    chk("post_rst_accepts", n_accepts, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/return_coin_sequencer.md
Name: return_coin_sequencer

Overview:
- Sequential controller for the vending machine's balance-return path.
- Owns the inactivity wait timer and decides when the balance is refunded.
- Breaks the balance into coins greedily and hands them one at a time to the coin hopper over a valid/ready handshake.
- Reports the value of each coin it returns so the balance-update logic can subtract it.

Parameters:
TOTAL_BITS, 31, width of balance values
COIN0_VALUE, 100, smallest coin value
COIN1_VALUE, 500, middle coin value
COIN2_VALUE, 1000, largest coin value; values are strictly ascending
WAIT_TIME, 10, inactivity cycles before automatic return (must be >= 1)

Ports:
clk  input  1  clock; all state updates on the rising edge
reset_n  input  1  synchronous, active-low reset
i_activity  input  1  coin inserted or item dispensed this cycle
i_trigger_return  input  1  user return request
i_current_total  input  TOTAL_BITS  current balance
i_hopper_ready  input  1  hopper accepts the presented coin
o_wait_time  output  32  remaining inactivity cycles
o_return_coin  output  3  one-hot coin presented; bit 0 = COIN0
o_return_valid  output  1  o_return_coin is valid
o_return_total  output  TOTAL_BITS  value of the coin accepted this cycle, else 0
o_busy  output  1  high in LATCH, RETURN and DONE; upstream must block coins and selections while high
o_done  output  1  one-cycle pulse when return completes
o_residual  output  1  sticky: last return left a nonzero amount below COIN0_VALUE

Behaviour:
- All outputs are registered except o_return_total, which is combinational: valid AND ready times the presented coin value.
- Reset (reset_n=0 at an edge):
  - state IDLE, wait_time 0, remaining 0;
  - o_return_coin 0, o_return_valid 0, o_busy 0, o_done 0, o_residual 0.
  - Reset overrides everything, including mid-return; an in-flight coin is dropped with no accept.
- IDLE:
  - i_activity -> WAIT, wait_time=WAIT_TIME.
  - i_trigger_return -> LATCH.
  - If both, trigger wins.
- WAIT, evaluated each cycle in priority order:
  - i_trigger_return -> LATCH;
  - else i_activity -> wait_time reloads to WAIT_TIME;
  - else wait_time decrements;
  - when it decrements from 1 to 0, the next state is LATCH.
  - wait_time never underflows.
- LATCH (one cycle): remaining = i_current_total; wait_time=0; o_residual cleared; go to RETURN.
- RETURN:
  - If remaining >= COIN2_VALUE, present bit 2; else if >= COIN1_VALUE, bit 1; else if >= COIN0_VALUE, bit 0; else go to DONE.
  - o_return_valid high while a coin is presented.
  - The coin stays stable until accepted (valid & ready).
  - On accept: remaining -= coin value; the next coin is presented the following cycle at the earliest, one accept per cycle max.
  - i_activity and i_trigger_return are ignored in RETURN.
- Entry to DONE:
  - valid low, o_return_coin 0;
  - o_residual = (remaining != 0);
  - o_done=1 for exactly one cycle; then IDLE.
- Zero balance at LATCH -> RETURN sees remaining < COIN0 -> DONE with no coins presented.
- Arithmetic:
  - Unsigned, TOTAL_BITS wide.
  - Comparisons are against zero-extended parameters.
  - No subtraction occurs when remaining < coin value.
- Latency from timeout to first coin valid: 2 cycles (LATCH, then RETURN with valid registered).

Test Plan:
- Timeout path. Stimulus: WAIT_TIME=10; one i_activity pulse with total=1600; ready held 1. Required response: o_wait_time counts 10..0; then coins bit2, bit1, bit0 on consecutive accepts, with o_return_total 1000, 500, 100; o_done pulses once; o_residual=0.
- Hopper backpressure. Stimulus: total=500; i_hopper_ready low for 3 cycles after valid rises. Required response: o_return_coin=3'b010 and valid held stable for 4 cycles; a single accept; o_return_total=500 only in the accept cycle.
- Activity reload. Stimulus: i_activity again when o_wait_time=3. Required response: o_wait_time reloads to 10; no return until 10 further idle cycles.
- Manual trigger and residual. Stimulus: i_trigger_return at o_wait_time=7 with total=1650. Required response: LATCH next cycle; returns 1000, 500, 100; DONE with o_residual=1.
- Zero balance. Stimulus: trigger in IDLE with total=0. Required response: no valid ever asserted; o_done pulses exactly 3 cycles after the trigger edge (LATCH, RETURN, DONE).
- Reset mid-return. Stimulus: reset_n=0 while a coin is valid and ready=0. Required response: next cycle all outputs are at reset values; no o_return_total pulse.
